// File: rtl/stopwatch_pkg.sv
// Shared constants, encodings and BCD helpers for the MM:SS stopwatch.
package stopwatch_pkg;

  localparam int unsigned DIGIT_W       = 4;
  localparam int unsigned DEF_MIN_LIMIT = 60;
  localparam int unsigned DEF_SEC_LIMIT = 60;

  localparam logic MODE_NORMAL = 1'b0;
  localparam logic MODE_ADJUST = 1'b1;

  localparam logic SEL_MIN = 1'b0;
  localparam logic SEL_SEC = 1'b1;

  typedef struct packed {
    logic [DIGIT_W-1:0] tens;
    logic [DIGIT_W-1:0] ones;
  } bcd_field_t;

  // Tens and ones digits of the last legal value (limit-1) of a field.
  function automatic logic [DIGIT_W-1:0] last_tens(input int unsigned limit);
    return DIGIT_W'((limit - 1) / 10);
  endfunction

  function automatic logic [DIGIT_W-1:0] last_ones(input int unsigned limit);
    return DIGIT_W'((limit - 1) % 10);
  endfunction

endpackage

// File: rtl/bcd_field_counter.sv
// Two-digit BCD counter wrapping at LIMIT-1 -> 00; carry is combinational on the wrapping increment.
module bcd_field_counter
  import stopwatch_pkg::*;
#(
  parameter int unsigned LIMIT = 60
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               inc,
  output logic [DIGIT_W-1:0] tens,
  output logic [DIGIT_W-1:0] ones,
  output logic               carry
);

  localparam logic [DIGIT_W-1:0] LAST_TENS = last_tens(LIMIT);
  localparam logic [DIGIT_W-1:0] LAST_ONES = last_ones(LIMIT);

  bcd_field_t field_q;
  bcd_field_t field_d;
  logic       at_last_c;

  assign at_last_c = (field_q.tens == LAST_TENS) && (field_q.ones == LAST_ONES);

  // Wrap at the limit takes priority over the ordinary ones/tens roll.
  always_comb begin
    field_d = field_q;
    carry   = 1'b0;
    if (inc) begin
      if (at_last_c) begin
        field_d.tens = '0;
        field_d.ones = '0;
        carry        = 1'b1;
      end else if (field_q.ones == DIGIT_W'(9)) begin
        field_d.ones = '0;
        field_d.tens = field_q.tens + DIGIT_W'(1);
      end else begin
        field_d.ones = field_q.ones + DIGIT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      field_q <= '0;
    end else begin
      field_q <= field_d;
    end
  end

  assign tens = field_q.tens;
  assign ones = field_q.ones;

endmodule

// File: rtl/stopwatch_counter.sv
// MM:SS stopwatch driven by rising edges of the selected timebase level.
// Optional pause toggle enabled by defining STOPWATCH_PAUSE_EN.
module stopwatch_counter
  import stopwatch_pkg::*;
#(
  parameter int unsigned MIN_LIMIT = DEF_MIN_LIMIT,
  parameter int unsigned SEC_LIMIT = DEF_SEC_LIMIT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick_in,
  input  logic               adj,
  input  logic               sel,
`ifdef STOPWATCH_PAUSE_EN
  input  logic               pause_pulse,
`endif
  output logic [DIGIT_W-1:0] min_tens,
  output logic [DIGIT_W-1:0] min_ones,
  output logic [DIGIT_W-1:0] sec_tens,
  output logic [DIGIT_W-1:0] sec_ones,
  output logic               paused,
  output logic               wrap_pulse
);

  logic tick_prev_q;
  logic tick_prev_d;
  logic tick_rise_c;
  logic wrap_q;
  logic wrap_d;
  logic paused_c;
  logic sec_inc_c;
  logic min_inc_c;
  logic sec_carry_c;
  logic min_carry_c;

`ifdef STOPWATCH_PAUSE_EN
  logic paused_q;
  logic paused_d;

  // Toggle takes effect next edge; this cycle's tick still sees the old value.
  always_comb begin
    paused_d = paused_q ^ pause_pulse;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      paused_q <= 1'b0;
    end else begin
      paused_q <= paused_d;
    end
  end

  assign paused_c = paused_q;
`else
  assign paused_c = 1'b0;
`endif

  assign tick_prev_d = tick_in;
  assign tick_rise_c = tick_in & ~tick_prev_q;

  // Normal mode chains minutes off the seconds carry; adjust bumps one field only.
  always_comb begin
    sec_inc_c = 1'b0;
    min_inc_c = 1'b0;
    wrap_d    = 1'b0;
    if (tick_rise_c) begin
      if (adj == MODE_ADJUST) begin
        sec_inc_c = (sel == SEL_SEC);
        min_inc_c = (sel == SEL_MIN);
      end else if (!paused_c) begin
        sec_inc_c = 1'b1;
        min_inc_c = sec_carry_c;
        wrap_d    = min_carry_c;
      end
    end
  end

  bcd_field_counter #(
    .LIMIT (SEC_LIMIT)
  ) u_sec (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (sec_inc_c),
    .tens  (sec_tens),
    .ones  (sec_ones),
    .carry (sec_carry_c)
  );

  bcd_field_counter #(
    .LIMIT (MIN_LIMIT)
  ) u_min (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (min_inc_c),
    .tens  (min_tens),
    .ones  (min_ones),
    .carry (min_carry_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_prev_q <= 1'b0;
      wrap_q      <= 1'b0;
    end else begin
      tick_prev_q <= tick_prev_d;
      wrap_q      <= wrap_d;
    end
  end

  assign wrap_pulse = wrap_q;
  assign paused     = paused_c;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Self-checking bench for stopwatch_counter: vector table, directed corners, random vs. arithmetic model.
module tb_stopwatch_counter;

  localparam int unsigned MIN_LIM = 60;
  localparam int unsigned SEC_LIM = 60;

  logic       clk;
  logic       rst_n;
  logic       tick_in;
  logic       adj;
  logic       sel;
  logic       pp;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic       paused;
  logic       wrap_pulse;

  int n_checks;
  int n_err;

  // Reference model state: plain integers
  int   m_min, m_sec;
  logic m_prev, m_paused, m_wrap;

  stopwatch_counter #(
    .MIN_LIMIT (MIN_LIM),
    .SEC_LIMIT (SEC_LIM)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tick_in     (tick_in),
    .adj         (adj),
    .sel         (sel),
`ifdef STOPWATCH_PAUSE_EN
    .pause_pulse (pp),
`endif
    .min_tens    (min_tens),
    .min_ones    (min_ones),
    .sec_tens    (sec_tens),
    .sec_ones    (sec_ones),
    .paused      (paused),
    .wrap_pulse  (wrap_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic tick;
    logic adj;
    logic sel;
    int   exp_min;
    int   exp_sec;
    logic exp_wrap;
  } vec_t;

  function automatic logic [17:0] pack_exp(input int mn, input int sc, input logic p, input logic w);
    return {4'(mn / 10), 4'(mn % 10), 4'(sc / 10), 4'(sc % 10), p, w};
  endfunction

  function automatic logic [17:0] pack_act();
    return {min_tens, min_ones, sec_tens, sec_ones, paused, wrap_pulse};
  endfunction

  task automatic chk(input string name, input logic [17:0] act, input logic [17:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_cycle(input logic t, input logic a, input logic s, input logic p);
    tick_in = t;
    adj     = a;
    sel     = s;
    pp      = p;
    @(posedge clk);
    #1;
  endtask

  // Model: seconds-of-hour arithmetic in normal mode, per-field modulo in adjust.
  task automatic model_step(input logic t, input logic a, input logic s, input logic p);
    int total;
    logic rise;
    rise   = t & ~m_prev;
    m_prev = t;
    m_wrap = 1'b0;
    if (rise) begin
      if (a) begin
        if (s) m_sec = (m_sec + 1) % SEC_LIM;
        else   m_min = (m_min + 1) % MIN_LIM;
      end else if (!m_paused) begin
        total = m_min * SEC_LIM + m_sec + 1;
        if (total == MIN_LIM * SEC_LIM) begin
          total  = 0;
          m_wrap = 1'b1;
        end
        m_min = total / SEC_LIM;
        m_sec = total % SEC_LIM;
      end
    end
`ifdef STOPWATCH_PAUSE_EN
    if (p) m_paused = ~m_paused;
`endif
  endtask

  task automatic step(input logic t, input logic a, input logic s, input logic p, input string name);
    drive_cycle(t, a, s, p);
    model_step(t, a, s, p);
    chk(name, pack_act(), pack_exp(m_min, m_sec, m_paused, m_wrap));
  endtask

  task automatic edge_n(input int n, input logic a, input logic s, input string name);
    for (int i = 0; i < n; i++) begin
      step(1'b1, a, s, 1'b0, name);
      step(1'b0, a, s, 1'b0, name);
    end
  endtask

  task automatic do_reset(input logic t);
    tick_in = t;
    adj     = 1'b0;
    sel     = 1'b0;
    pp      = 1'b0;
    rst_n   = 1'b0;
    #3;
    chk("reset_state", pack_act(), 18'd0);
    @(negedge clk);
    rst_n    = 1'b1;
    m_min    = 0;
    m_sec    = 0;
    m_prev   = 1'b0;
    m_paused = 1'b0;
    m_wrap   = 1'b0;
  endtask

  vec_t vecs[10];
  logic seen_wrap;
  int   wrap_cnt;

  initial begin
    n_checks = 0;
    n_err    = 0;
    rst_n    = 1'b0;
    tick_in  = 1'b0;
    adj      = 1'b0;
    sel      = 1'b0;
    pp       = 1'b0;

    vecs[0] = '{1'b1, 1'b0, 1'b0, 0, 1, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 0, 1, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 1'b0, 0, 1, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 1, 1, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 1, 1, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 1, 2, 1'b0};
    vecs[6] = '{1'b0, 1'b0, 1'b1, 1, 2, 1'b0};
    vecs[7] = '{1'b1, 1'b0, 1'b1, 1, 3, 1'b0};
    vecs[8] = '{1'b0, 1'b1, 1'b0, 1, 3, 1'b0};
    vecs[9] = '{1'b1, 1'b1, 1'b0, 2, 3, 1'b0};

    // Vector table
    #12;
    do_reset(1'b0);
    for (int i = 0; i < 10; i++) begin
      drive_cycle(vecs[i].tick, vecs[i].adj, vecs[i].sel, 1'b0);
      chk($sformatf("vec%0d", i), pack_act(),
          pack_exp(vecs[i].exp_min, vecs[i].exp_sec, 1'b0, vecs[i].exp_wrap));
    end

    // 61 edges -> 01:01, never a wrap
    do_reset(1'b0);
    seen_wrap = 1'b0;
    for (int i = 0; i < 61; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, "count61");
      seen_wrap |= wrap_pulse;
      step(1'b0, 1'b0, 1'b0, 1'b0, "count61");
      seen_wrap |= wrap_pulse;
    end
    chk("at_01_01", pack_act(), pack_exp(1, 1, 1'b0, 1'b0));
    chk("no_wrap_61", 18'(seen_wrap), 18'd0);

    // Count on to 59:59, then full rollover
    edge_n(3599 - 61, 1'b0, 1'b0, "count_to_5959");
    chk("at_59_59", pack_act(), pack_exp(59, 59, 1'b0, 1'b0));
    wrap_cnt = 0;
    step(1'b1, 1'b0, 1'b0, 1'b0, "rollover");
    chk("rollover_00_00", pack_act(), pack_exp(0, 0, 1'b0, 1'b1));
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, "post_roll");
      if (wrap_pulse) wrap_cnt++;
    end
    chk("wrap_one_cycle", 18'(wrap_cnt), 18'd0);

    // Adjust seconds at 00:59 -> 00:00 without carry, then minutes x3
    edge_n(59, 1'b1, 1'b1, "adj_sec_load");
    chk("adj_at_00_59", pack_act(), pack_exp(0, 59, 1'b0, 1'b0));
    step(1'b1, 1'b1, 1'b1, 1'b0, "adj_sec_wrap");
    chk("adj_sec_wrap_nocarry", pack_act(), pack_exp(0, 0, 1'b0, 1'b0));
    step(1'b0, 1'b1, 1'b0, 1'b0, "adj_sel_min");
    edge_n(3, 1'b1, 1'b0, "adj_min3");
    chk("adj_at_03_00", pack_act(), pack_exp(3, 0, 1'b0, 1'b0));

    // Held-high tick gives one increment
    step(1'b1, 1'b0, 1'b0, 1'b0, "held_rise");
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 1'b0, 1'b0, "held_high");
    chk("held_one_inc", pack_act(), pack_exp(3, 1, 1'b0, 1'b0));

    // Tick already high at reset release counts as an edge
    do_reset(1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, "high_at_release");
    chk("release_edge", pack_act(), pack_exp(0, 1, 1'b0, 1'b0));

`ifdef STOPWATCH_PAUSE_EN
    // Pause request coinciding with a tick: tick uses the old pause state
    do_reset(1'b0);
    edge_n(5, 1'b0, 1'b0, "pause_pre");
    step(1'b1, 1'b0, 1'b0, 1'b1, "pause_same_cycle");
    chk("pause_00_06", pack_act(), pack_exp(0, 6, 1'b1, 1'b0));
    step(1'b0, 1'b0, 1'b0, 1'b0, "pause_low");
    edge_n(3, 1'b0, 1'b0, "paused_normal");
    chk("paused_hold", pack_act(), pack_exp(0, 6, 1'b1, 1'b0));
    edge_n(1, 1'b1, 1'b1, "paused_adjust");
    chk("paused_adj_inc", pack_act(), pack_exp(0, 7, 1'b1, 1'b0));
`endif

    // Randomized traffic against the model
    do_reset(1'b0);
    for (int i = 0; i < 1500; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 15) == 0), "random");
    end

    // Asynchronous reset mid-count at 12:34
    do_reset(1'b0);
    edge_n(12, 1'b1, 1'b0, "load_min");
    edge_n(34, 1'b1, 1'b1, "load_sec");
    chk("at_12_34", pack_act(), pack_exp(12, 34, 1'b0, 1'b0));
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset", pack_act(), 18'd0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
